switch_debounce_ctrl: RTL and testbench
=======================================

Name: switch_debounce_ctrl

Overview:
Avalon-MM slave controller for a single front-panel toggle switch. It synchronizes and debounces the raw switch input and records qualified edges in a sticky capture flag. It also counts debounced toggles and optionally raises an interrupt to the HPS. It sits on the lightweight HPS-to-FPGA bridge in place of a bare PIO input.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive clk cycles a changed synchronized level must hold before it is accepted (1 ms at 50 MHz); legal range 2..2^20.
CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
EVT_W, 16, width of the debounced toggle event counter.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  2  Avalon word address
chipselect  input  1  Avalon slave select
write_n  input  1  active-low Avalon write strobe
writedata  input  32  Avalon write data
readdata  output  32  registered Avalon read data
in_port  input  1  raw, asynchronous switch level
irq  output  1  level interrupt to HPS, active high

Behaviour:
- Reset: all internal state and outputs clear. readdata=0, irq=0, sync flops=0, stable=0, debounce count=0, ctrl=0, capture=0, event counter=0.
- Synchronizer: two-flop chain on in_port; sync lags in_port by 2 cycles.
- Debounce counter:
  - When sync != stable, count increments each cycle.
  - When sync != stable and count == DEBOUNCE_CYCLES-1: stable <= sync and count <= 0.
  - Any cycle with sync == stable: count <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - Latency: a clean in_port step is reflected in stable exactly 2+DEBOUNCE_CYCLES cycles later.
- Edge event: one-cycle pulse when stable changes. rise = 0->1, fall = 1->0.
- Register map (word addresses):
  - 0 DATA (RO): bit0 = stable; bit1 = sync (raw synchronized level); other bits 0.
  - 1 CTRL (RW): bit0 = irq_en; bits[2:1] = edge_sel (00 none, 01 rise, 10 fall, 11 both); other bits read 0.
  - 2 CAPTURE (RW1C): bit0 = captured flag, set by a qualified edge per edge_sel; bit1 = direction of the most recent qualified edge (1 = rise), updated only on a qualified edge. Writing 1 to bit0 clears the flag; bit1 is not writable.
  - 3 EVENTS (RO, write clears): debounced toggle count, EVT_W bits zero-extended. Increments on every stable change regardless of edge_sel. Wraps from 2^EVT_W-1 to 0. Any write clears it.
- Write qualifier: chipselect=1 and write_n=0, sampled at a clk edge. Writes to address 0 are ignored.
- Read: readdata <= mux(address) on every clk edge, with no read strobe. Read latency is 1 cycle.
- Simultaneous events:
  - A qualified edge in the same cycle as a W1C of CAPTURE bit0: set wins, flag stays 1.
  - A toggle in the same cycle as an EVENTS write: counter loads 1.
- Changing edge_sel does not retroactively set or clear CAPTURE.
- An asynchronous reset mid-debounce discards the partial count. After release, stable re-qualifies from 0 through the normal debounce path.

Optional Feature:
Macro SWITCH_DEBOUNCE_IRQ_EN.
- Defined: irq is registered; irq <= irq_en & CAPTURE.bit0. irq asserts 1 cycle after the flag sets and deasserts 1 cycle after the flag is cleared or irq_en is written 0.
- Not defined: irq is tied to 0. CTRL bit0 is not implemented and reads 0. The rest of the register map is unchanged.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8.
1. Reset: assert reset_n=0 mid-run -> readdata=0 and irq=0 immediately; after release, reads of addresses 0..3 all return 0.
2. Clean step: in_port 0->1 at cycle t -> DATA bit0=1 observable in readdata at t+11 (2 sync + 8 debounce + 1 read); EVENTS reads 1.
3. Glitch: 7-cycle high pulse on in_port -> DATA bit0 stays 0, EVENTS stays 0, CAPTURE stays 0.
4. Edge select and capture: with edge_sel=10, a clean rise followed by a clean fall -> CAPTURE reads 0x1 only after the fall; writing 0x1 clears it to 0; with edge_sel=11, a further rise reads 0x3.
5. Collisions: W1C of CAPTURE in the same cycle as a qualified edge -> CAPTURE bit0 remains 1. An EVENTS write in the same cycle as a toggle -> EVENTS reads 1.
6. IRQ with SWITCH_DEBOUNCE_IRQ_EN defined: irq_en=1, a qualified edge -> irq=1 one cycle after the flag sets; W1C clears irq one cycle later. Rebuild without the macro -> irq always 0 and CTRL reads 0x6 after writing 0x7.

Source files
------------

// File: rtl/switch_debounce_ctrl_if.sv
// Avalon-MM slave bus bundle for switch_debounce_ctrl.
interface switch_debounce_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/switch_debounce_ctrl.sv
// Debounced front-panel switch with sticky edge capture and toggle counter on Avalon-MM.
// Optional interrupt output is enabled by defining SWITCH_DEBOUNCE_IRQ_EN.
module switch_debounce_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 20,
  parameter int EVT_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  switch_debounce_ctrl_if.slave bus,
  input  logic                  in_port,
  output logic                  irq
);

  logic             sync_meta;
  logic             sync;
  logic             stable;
  logic [CNT_W-1:0] count;
  logic [1:0]       edge_sel;
  logic             flag;
  logic             dir;
  logic [EVT_W-1:0] events;
  logic             irq_en_bit;
  logic             wr_en;
  logic             toggle;
  logic             qualified;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata[31:3];

  // toggle fires on the exact cycle stable is about to take the new level
  always_comb begin
    toggle    = (sync != stable) && (count == CNT_W'(DEBOUNCE_CYCLES - 1));
    qualified = toggle && (sync ? edge_sel[0] : edge_sel[1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      stable    <= 1'b0;
      count     <= '0;
    end else begin
      sync_meta <= in_port;
      sync      <= sync_meta;
      if (sync == stable) begin
        count <= '0;
      end else if (toggle) begin
        stable <= sync;
        count  <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // a qualified edge outranks a same-cycle W1C, and a toggle outranks an EVENTS clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_sel <= 2'b00;
      flag     <= 1'b0;
      dir      <= 1'b0;
      events   <= '0;
    end else begin
      if (wr_en && bus.address == 2'd1)
        edge_sel <= bus.writedata[2:1];

      if (qualified) begin
        flag <= 1'b1;
        dir  <= sync;
      end else if (wr_en && bus.address == 2'd2 && bus.writedata[0]) begin
        flag <= 1'b0;
      end

      if (wr_en && bus.address == 2'd3)
        events <= toggle ? EVT_W'(1) : '0;
      else if (toggle)
        events <= events + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      case (bus.address)
        2'd0:    bus.readdata <= {30'd0, sync, stable};
        2'd1:    bus.readdata <= {29'd0, edge_sel, irq_en_bit};
        2'd2:    bus.readdata <= {30'd0, dir, flag};
        default: bus.readdata <= 32'(events);
      endcase
    end
  end

`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_en && bus.address == 2'd1)
        irq_en <= bus.writedata[0];
      irq <= irq_en & flag;
    end
  end

  assign irq_en_bit = irq_en;
`else
  assign irq_en_bit = 1'b0;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// Self-checking bench for switch_debounce_ctrl: directed vector table, corner sequences,
// and random traffic against a window-based reference model.
module tb_switch_debounce_ctrl;

  localparam int DEB = 8;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic in_port;
  logic irq;

  switch_debounce_ctrl_if bus_if();

  switch_debounce_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(4),
    .EVT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if),
    .in_port(in_port),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: stable flips once the last DEB synchronized samples all disagree with it
  bit          m_inq[$];
  bit          m_win[$];
  bit          m_stable;
  bit          m_irq_en;
  bit  [1:0]   m_sel;
  bit          m_flag;
  bit          m_dir;
  bit  [15:0]  m_events;
  logic [31:0] exp_rd;
  logic        exp_irq;

  function automatic void modelReset();
    m_inq.delete();
    m_inq.push_back(1'b0);
    m_inq.push_back(1'b0);
    m_win.delete();
    m_stable = 1'b0;
    m_irq_en = 1'b0;
    m_sel    = 2'b00;
    m_flag   = 1'b0;
    m_dir    = 1'b0;
    m_events = 16'd0;
    exp_rd   = 32'd0;
    exp_irq  = 1'b0;
  endfunction

  function automatic void modelEdge(input logic inp, input logic [1:0] a, input logic wr,
                                    input logic [31:0] wd);
    bit s;
    bit tog;
    bit new_st;
    bit qual;
    case (a)
      2'd0:    exp_rd = {30'd0, m_inq[0], m_stable};
      2'd1:    exp_rd = {29'd0, m_sel, m_irq_en};
      2'd2:    exp_rd = {30'd0, m_dir, m_flag};
      default: exp_rd = {16'd0, m_events};
    endcase
    exp_irq = IRQ_ON & m_irq_en & m_flag;

    m_inq.push_back(inp);
    s = m_inq.pop_front();
    m_win.push_back(s);
    if (m_win.size() > DEB) void'(m_win.pop_front());
    tog = (m_win.size() == DEB);
    foreach (m_win[i]) if (m_win[i] == m_stable) tog = 1'b0;
    new_st = tog ? ~m_stable : m_stable;
    qual   = tog && (new_st ? m_sel[0] : m_sel[1]);

    if (qual) begin
      m_flag = 1'b1;
      m_dir  = new_st;
    end else if (wr && a == 2'd2 && wd[0]) begin
      m_flag = 1'b0;
    end
    if (wr && a == 2'd3) m_events = tog ? 16'd1 : 16'd0;
    else if (tog)        m_events = m_events + 16'd1;
    if (wr && a == 2'd1) begin
      m_sel    = wd[2:1];
      m_irq_en = IRQ_ON & wd[0];
    end
    m_stable = new_st;
  endfunction

  // drives one set of inputs for 'cycles' clocks (write only on the first) and returns on a negedge
  task automatic applyStimulus(input logic inp, input logic [1:0] a, input logic wr,
                               input logic [31:0] wd, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_port           = inp;
      bus_if.address    = a;
      bus_if.chipselect = wr && (i == 0);
      bus_if.write_n    = !(wr && (i == 0));
      bus_if.writedata  = wd;
      modelEdge(inp, a, wr && (i == 0), wd);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        in_lvl;
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wd;
    int          cycles;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic       lvl;
    int         run;
    logic [1:0] ra;
    logic       rwr;
    logic [31:0] rwd;

    reset_n           = 1'b0;
    in_port           = 1'b0;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'd0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_rd", bus_if.readdata, 32'd0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;

    vecs.push_back('{"step_sync_only",  1'b1, 2'd0, 1'b0, 32'd0, 10, 32'h2});
    vecs.push_back('{"step_stable",     1'b1, 2'd0, 1'b0, 32'd0,  1, 32'h3});
    vecs.push_back('{"step_events",     1'b1, 2'd3, 1'b0, 32'd0,  1, 32'h1});
    vecs.push_back('{"step_no_capture", 1'b1, 2'd2, 1'b0, 32'd0,  1, 32'h0});
    vecs.push_back('{"fall_stable",     1'b0, 2'd0, 1'b0, 32'd0, 11, 32'h0});
    vecs.push_back('{"events_two",      1'b0, 2'd3, 1'b0, 32'd0,  1, 32'h2});
    vecs.push_back('{"events_clear",    1'b0, 2'd3, 1'b1, 32'd0,  2, 32'h0});
    vecs.push_back('{"glitch_sync",     1'b1, 2'd0, 1'b0, 32'd0,  7, 32'h2});
    vecs.push_back('{"glitch_end",      1'b0, 2'd0, 1'b0, 32'd0, 12, 32'h0});
    vecs.push_back('{"glitch_events",   1'b0, 2'd3, 1'b0, 32'd0,  1, 32'h0});
    vecs.push_back('{"glitch_capture",  1'b0, 2'd2, 1'b0, 32'd0,  1, 32'h0});
    vecs.push_back('{"sel_fall",        1'b0, 2'd1, 1'b1, 32'h4,  2, 32'h4});
    vecs.push_back('{"rise_ignored",    1'b1, 2'd2, 1'b0, 32'd0, 11, 32'h0});
    vecs.push_back('{"fall_pending",    1'b0, 2'd2, 1'b0, 32'd0, 10, 32'h0});
    vecs.push_back('{"fall_captured",   1'b0, 2'd2, 1'b0, 32'd0,  1, 32'h1});
    vecs.push_back('{"w1c_clear",       1'b0, 2'd2, 1'b1, 32'h1,  2, 32'h0});
    vecs.push_back('{"sel_both",        1'b0, 2'd1, 1'b1, 32'h6,  2, 32'h6});
    vecs.push_back('{"rise_captured",   1'b1, 2'd2, 1'b0, 32'd0, 11, 32'h3});
    vecs.push_back('{"events_three",    1'b1, 2'd3, 1'b0, 32'd0,  1, 32'h3});
    vecs.push_back('{"ctrl_rw",         1'b1, 2'd1, 1'b1, 32'h7,  2, IRQ_ON ? 32'h7 : 32'h6});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].in_lvl, vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].cycles);
      checkOutput(vecs[i].name, bus_if.readdata, vecs[i].exp_rd);
    end

    // interrupt follows the flag by one cycle in each direction
    checkOutput("irq_level", {31'd0, irq}, {31'd0, IRQ_ON});
    applyStimulus(1'b1, 2'd2, 1'b1, 32'h1, 1);
    checkOutput("irq_hold", {31'd0, irq}, {31'd0, IRQ_ON});
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0, 1);
    checkOutput("irq_clear", {31'd0, irq}, 32'd0);
    checkOutput("irq_clear_rd", bus_if.readdata, 32'h2);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 10);
    checkOutput("irq_pre_edge", {31'd0, irq}, 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0, 1);
    checkOutput("irq_set", {31'd0, irq}, {31'd0, IRQ_ON});
    checkOutput("irq_set_rd", bus_if.readdata, 32'h1);

    // W1C lands on the same edge as a qualified rise
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0, 9);
    applyStimulus(1'b1, 2'd2, 1'b1, 32'h1, 1);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0, 1);
    checkOutput("collide_w1c", bus_if.readdata, 32'h3);

    // EVENTS clear lands on the same edge as a toggle
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h0, 9);
    applyStimulus(1'b0, 2'd3, 1'b1, 32'h0, 1);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h0, 1);
    checkOutput("collide_events", bus_if.readdata, 32'h1);

    // asynchronous reset in the middle of a debounce
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h0, 4);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrun_reset_rd", bus_if.readdata, 32'd0);
    checkOutput("midrun_reset_irq", {31'd0, irq}, 32'd0);
    in_port = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
    for (int a = 0; a < 4; a++) begin
      applyStimulus(1'b0, 2'(a), 1'b0, 32'h0, 1);
      checkOutput($sformatf("post_reset_addr%0d", a), bus_if.readdata, 32'd0);
    end

    lvl = 1'b0;
    run = 0;
    for (int n = 0; n < 3000; n++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(1, 20);
      end
      run--;
      ra  = 2'($urandom_range(0, 3));
      rwr = ($urandom_range(0, 11) == 0);
      rwd = $urandom;
      if (n == 1500) begin
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rand_reset_rd", bus_if.readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        modelReset();
      end
      applyStimulus(lvl, ra, rwr, rwd, 1);
      checkOutput("rand_rd", bus_if.readdata, exp_rd);
      checkOutput("rand_irq", {31'd0, irq}, {31'd0, exp_irq});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
